// File: rtl/rv32i_pkg.sv
// Shared RV32I execute-stage types: ALU opcode classes, ALU functions, funct3 codes.
package rv32i_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;

   // Coarse ALU operation class produced by the decoder
   typedef enum logic [1:0] {
      ALU_OP_ADD    = 2'b00,
      ALU_OP_BRANCH = 2'b01,
      ALU_OP_RTYPE  = 2'b10,
      ALU_OP_ITYPE  = 2'b11
   } alu_op_t;

   // Concrete ALU function after funct3/funct7 decode
   typedef enum logic [3:0] {
      FN_ADD, FN_SUB, FN_SLL, FN_SLT, FN_SLTU,
      FN_XOR, FN_SRL, FN_SRA, FN_OR,  FN_AND
   } alu_fn_t;

   // ALU funct3 codes
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SR      = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   // Branch funct3 codes
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Control bits carried through the EX/MEM register
   typedef struct packed {
      logic       mem_to_reg;
      logic       reg_wr;
      logic       mem_rd;
      logic       mem_wr;
      logic [1:0] rw_sel;
   } ex_ctrl_t;

   // Map operation class + funct fields to an ALU function.
   // Immediate forms never subtract; funct7[5] there only distinguishes SRAI.
   function automatic alu_fn_t decode_alu_fn(input alu_op_t op,
                                             input logic [2:0] f3,
                                             input logic f7b5);
      alu_fn_t fn;
      fn = FN_ADD;
      if (op == ALU_OP_RTYPE || op == ALU_OP_ITYPE) begin
         case (f3)
            F3_ADD_SUB: fn = (op == ALU_OP_RTYPE && f7b5) ? FN_SUB : FN_ADD;
            F3_SLL:     fn = FN_SLL;
            F3_SLT:     fn = FN_SLT;
            F3_SLTU:    fn = FN_SLTU;
            F3_XOR:     fn = FN_XOR;
            F3_SR:      fn = f7b5 ? FN_SRA : FN_SRL;
            F3_OR:      fn = FN_OR;
            F3_AND:     fn = FN_AND;
            default:    fn = FN_ADD;
         endcase
      end
      return fn;
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU; shift amount is taken from b_i[4:0].
module alu
   import rv32i_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  alu_fn_t         fn_i,
   output logic [XLEN-1:0] result_o
);

   logic [4:0] shamt;

   assign shamt = b_i[4:0];

   // Function select; arithmetic wraps modulo 2^XLEN
   always_comb begin
      result_o = '0;
      case (fn_i)
         FN_ADD:  result_o = a_i + b_i;
         FN_SUB:  result_o = a_i - b_i;
         FN_SLL:  result_o = a_i << shamt;
         FN_SLT:  result_o = XLEN'($signed(a_i) < $signed(b_i));
         FN_SLTU: result_o = XLEN'(a_i < b_i);
         FN_XOR:  result_o = a_i ^ b_i;
         FN_SRL:  result_o = a_i >> shamt;
         FN_SRA:  result_o = XLEN'($signed(a_i) >>> shamt);
         FN_OR:   result_o = a_i | b_i;
         FN_AND:  result_o = a_i & b_i;
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and EX/MEM register.
module execute_stage
   import rv32i_pkg::*;
#(
   parameter int unsigned     XLEN      = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC4 = XLEN'(32'h0000_0004)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_clk_en,
   input  logic            i_stall,
   input  logic            i_flush,
   input  logic [XLEN-1:0] i_id_pc,
   input  logic [XLEN-1:0] i_id_pc_plus_4,
   input  logic [XLEN-1:0] i_id_rs1_data,
   input  logic [XLEN-1:0] i_id_rs2_data,
   input  logic [4:0]      i_id_rs1_addr,
   input  logic [4:0]      i_id_rs2_addr,
   input  logic [4:0]      i_id_reg_dest,
   input  logic [XLEN-1:0] i_id_imm,
   input  logic [2:0]      i_id_funct3,
   input  logic [6:0]      i_id_funct7,
   input  logic [1:0]      i_id_alu_op,
   input  logic            i_id_alu_src,
   input  logic            i_id_lui,
   input  logic            i_id_auipc,
   input  logic            i_id_branch,
   input  logic            i_id_jal,
   input  logic            i_id_jalr,
   input  logic            i_id_mem_to_reg,
   input  logic            i_id_reg_wr,
   input  logic            i_id_mem_rd,
   input  logic            i_id_mem_wr,
   input  logic [1:0]      i_id_rw_sel,
   input  logic            i_ma_reg_wr,
   input  logic [4:0]      i_ma_reg_dest,
   input  logic [XLEN-1:0] i_ma_result,
   input  logic            i_wb_reg_wr,
   input  logic [4:0]      i_wb_reg_dest,
   input  logic [XLEN-1:0] i_wb_data,
   output logic            o_ex_mem_to_reg,
   output logic            o_ex_reg_wr,
   output logic            o_ex_mem_rd,
   output logic            o_ex_mem_wr,
   output logic [1:0]      o_ex_rw_sel,
   output logic [XLEN-1:0] o_ex_pc_plus_4,
   output logic [XLEN-1:0] o_ex_alu_result,
   output logic [XLEN-1:0] o_ex_reg_read_data2,
   output logic [4:0]      o_ex_reg_dest,
   output logic [2:0]      o_ex_funct3,
   output logic [6:0]      o_ex_funct7,
   output logic            o_branch_taken,
   output logic [XLEN-1:0] o_branch_target
);

   logic [XLEN-1:0] fwd_rs1, fwd_rs2;
   logic [XLEN-1:0] op_a, op_b;
   logic [XLEN-1:0] alu_res, ex_result;
   logic [XLEN-1:0] jalr_sum;
   alu_fn_t         alu_fn;
   logic            br_cond;

   ex_ctrl_t        ctrl_q, ctrl_d;
   logic [XLEN-1:0] pc4_q, pc4_d;
   logic [XLEN-1:0] alu_q, alu_d;
   logic [XLEN-1:0] rd2_q, rd2_d;
   logic [4:0]      dest_q, dest_d;
   logic [2:0]      f3_q, f3_d;
   logic [6:0]      f7_q, f7_d;

   // Operand forwarding: MA beats WB beats register file; x0 is never forwarded
   always_comb begin
      fwd_rs1 = i_id_rs1_data;
      fwd_rs2 = i_id_rs2_data;
      if (i_ma_reg_wr && i_ma_reg_dest != 5'd0 && i_ma_reg_dest == i_id_rs1_addr)
         fwd_rs1 = i_ma_result;
      else if (i_wb_reg_wr && i_wb_reg_dest != 5'd0 && i_wb_reg_dest == i_id_rs1_addr)
         fwd_rs1 = i_wb_data;
      if (i_ma_reg_wr && i_ma_reg_dest != 5'd0 && i_ma_reg_dest == i_id_rs2_addr)
         fwd_rs2 = i_ma_result;
      else if (i_wb_reg_wr && i_wb_reg_dest != 5'd0 && i_wb_reg_dest == i_id_rs2_addr)
         fwd_rs2 = i_wb_data;
   end

   // ALU operand selection and function decode
   always_comb begin
      op_a   = i_id_auipc   ? i_id_pc  : fwd_rs1;
      op_b   = i_id_alu_src ? i_id_imm : fwd_rs2;
      alu_fn = decode_alu_fn(alu_op_t'(i_id_alu_op), i_id_funct3, i_id_funct7[5]);
   end

   alu #(
      .XLEN(XLEN)
   ) u_alu (
      .a_i     (op_a),
      .b_i     (op_b),
      .fn_i    (alu_fn),
      .result_o(alu_res)
   );

   assign ex_result = i_id_lui ? i_id_imm : alu_res;

   // Branch comparator on forwarded register operands
   always_comb begin
      br_cond = 1'b0;
      case (i_id_funct3)
         F3_BEQ:  br_cond = (fwd_rs1 == fwd_rs2);
         F3_BNE:  br_cond = (fwd_rs1 != fwd_rs2);
         F3_BLT:  br_cond = ($signed(fwd_rs1) <  $signed(fwd_rs2));
         F3_BGE:  br_cond = ($signed(fwd_rs1) >= $signed(fwd_rs2));
         F3_BLTU: br_cond = (fwd_rs1 <  fwd_rs2);
         F3_BGEU: br_cond = (fwd_rs1 >= fwd_rs2);
         default: br_cond = 1'b0;
      endcase
   end

   // Fetch redirect; suppressed while the stage is frozen or stalled
   always_comb begin
      jalr_sum        = fwd_rs1 + i_id_imm;
      o_branch_target = i_id_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (i_id_pc + i_id_imm);
      o_branch_taken  = ((i_id_branch & br_cond) | i_id_jal | i_id_jalr)
                        & i_clk_en & ~i_stall;
   end

   // EX/MEM next state: hold when disabled, bubble on flush, hold on stall, else load
   always_comb begin
      ctrl_d = ctrl_q;
      pc4_d  = pc4_q;
      alu_d  = alu_q;
      rd2_d  = rd2_q;
      dest_d = dest_q;
      f3_d   = f3_q;
      f7_d   = f7_q;
      if (i_clk_en) begin
         if (i_flush) begin
            ctrl_d = '0;
            pc4_d  = '0;
            alu_d  = '0;
            rd2_d  = '0;
            dest_d = '0;
            f3_d   = '0;
            f7_d   = '0;
         end else if (!i_stall) begin
            ctrl_d.mem_to_reg = i_id_mem_to_reg;
            ctrl_d.reg_wr     = i_id_reg_wr;
            ctrl_d.mem_rd     = i_id_mem_rd;
            ctrl_d.mem_wr     = i_id_mem_wr;
            ctrl_d.rw_sel     = i_id_rw_sel;
            pc4_d             = i_id_pc_plus_4;
            alu_d             = ex_result;
            rd2_d             = fwd_rs2;
            dest_d            = i_id_reg_dest;
            f3_d              = i_id_funct3;
            f7_d              = i_id_funct7;
         end
      end
   end

   // EX/MEM register with asynchronous reset
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ctrl_q <= '0;
         pc4_q  <= RESET_PC4;
         alu_q  <= '0;
         rd2_q  <= '0;
         dest_q <= '0;
         f3_q   <= '0;
         f7_q   <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         pc4_q  <= pc4_d;
         alu_q  <= alu_d;
         rd2_q  <= rd2_d;
         dest_q <= dest_d;
         f3_q   <= f3_d;
         f7_q   <= f7_d;
      end
   end

   assign o_ex_mem_to_reg     = ctrl_q.mem_to_reg;
   assign o_ex_reg_wr         = ctrl_q.reg_wr;
   assign o_ex_mem_rd         = ctrl_q.mem_rd;
   assign o_ex_mem_wr         = ctrl_q.mem_wr;
   assign o_ex_rw_sel         = ctrl_q.rw_sel;
   assign o_ex_pc_plus_4      = pc4_q;
   assign o_ex_alu_result     = alu_q;
   assign o_ex_reg_read_data2 = rd2_q;
   assign o_ex_reg_dest       = dest_q;
   assign o_ex_funct3         = f3_q;
   assign o_ex_funct7         = f7_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus pushes expectations, monitor pops and compares.
module tb_execute_stage;

   localparam int LOAD   = 0;
   localparam int HOLD   = 1;
   localparam int BUBBLE = 2;

   logic        i_clk = 1'b0;
   logic        i_rst, i_clk_en, i_stall, i_flush;
   logic [31:0] i_id_pc, i_id_pc_plus_4, i_id_rs1_data, i_id_rs2_data, i_id_imm;
   logic [4:0]  i_id_rs1_addr, i_id_rs2_addr, i_id_reg_dest;
   logic [2:0]  i_id_funct3;
   logic [6:0]  i_id_funct7;
   logic [1:0]  i_id_alu_op, i_id_rw_sel;
   logic        i_id_alu_src, i_id_lui, i_id_auipc, i_id_branch, i_id_jal, i_id_jalr;
   logic        i_id_mem_to_reg, i_id_reg_wr, i_id_mem_rd, i_id_mem_wr;
   logic        i_ma_reg_wr, i_wb_reg_wr;
   logic [4:0]  i_ma_reg_dest, i_wb_reg_dest;
   logic [31:0] i_ma_result, i_wb_data;
   logic        o_ex_mem_to_reg, o_ex_reg_wr, o_ex_mem_rd, o_ex_mem_wr;
   logic [1:0]  o_ex_rw_sel;
   logic [31:0] o_ex_pc_plus_4, o_ex_alu_result, o_ex_reg_read_data2;
   logic [4:0]  o_ex_reg_dest;
   logic [2:0]  o_ex_funct3;
   logic [6:0]  o_ex_funct7;
   logic        o_branch_taken;
   logic [31:0] o_branch_target;

   execute_stage dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .i_stall(i_stall), .i_flush(i_flush),
      .i_id_pc(i_id_pc), .i_id_pc_plus_4(i_id_pc_plus_4),
      .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data),
      .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr), .i_id_reg_dest(i_id_reg_dest),
      .i_id_imm(i_id_imm), .i_id_funct3(i_id_funct3), .i_id_funct7(i_id_funct7),
      .i_id_alu_op(i_id_alu_op), .i_id_alu_src(i_id_alu_src), .i_id_lui(i_id_lui),
      .i_id_auipc(i_id_auipc), .i_id_branch(i_id_branch), .i_id_jal(i_id_jal), .i_id_jalr(i_id_jalr),
      .i_id_mem_to_reg(i_id_mem_to_reg), .i_id_reg_wr(i_id_reg_wr), .i_id_mem_rd(i_id_mem_rd),
      .i_id_mem_wr(i_id_mem_wr), .i_id_rw_sel(i_id_rw_sel),
      .i_ma_reg_wr(i_ma_reg_wr), .i_ma_reg_dest(i_ma_reg_dest), .i_ma_result(i_ma_result),
      .i_wb_reg_wr(i_wb_reg_wr), .i_wb_reg_dest(i_wb_reg_dest), .i_wb_data(i_wb_data),
      .o_ex_mem_to_reg(o_ex_mem_to_reg), .o_ex_reg_wr(o_ex_reg_wr), .o_ex_mem_rd(o_ex_mem_rd),
      .o_ex_mem_wr(o_ex_mem_wr), .o_ex_rw_sel(o_ex_rw_sel), .o_ex_pc_plus_4(o_ex_pc_plus_4),
      .o_ex_alu_result(o_ex_alu_result), .o_ex_reg_read_data2(o_ex_reg_read_data2),
      .o_ex_reg_dest(o_ex_reg_dest), .o_ex_funct3(o_ex_funct3), .o_ex_funct7(o_ex_funct7),
      .o_branch_taken(o_branch_taken), .o_branch_target(o_branch_target)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      string       name;
      logic        taken;
      logic [31:0] target;
      bit          chk_regs;
      logic [31:0] alu, pc4, rd2;
      logic [4:0]  dest;
      logic        reg_wr, mem_wr, mem_rd, mem_to_reg;
      logic [1:0]  rw_sel;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        cur;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_in();
      i_clk_en = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
      i_id_pc = '0; i_id_pc_plus_4 = '0; i_id_rs1_data = '0; i_id_rs2_data = '0; i_id_imm = '0;
      i_id_rs1_addr = '0; i_id_rs2_addr = '0; i_id_reg_dest = '0;
      i_id_funct3 = '0; i_id_funct7 = '0; i_id_alu_op = '0; i_id_rw_sel = '0;
      i_id_alu_src = 0; i_id_lui = 0; i_id_auipc = 0; i_id_branch = 0; i_id_jal = 0; i_id_jalr = 0;
      i_id_mem_to_reg = 0; i_id_reg_wr = 0; i_id_mem_rd = 0; i_id_mem_wr = 0;
      i_ma_reg_wr = 0; i_ma_reg_dest = '0; i_ma_result = '0;
      i_wb_reg_wr = 0; i_wb_reg_dest = '0; i_wb_data = '0;
   endtask

   // Update the expected EX/MEM contents for this cycle, queue it, advance one cycle
   task automatic step(input string nm, input int mode, input logic [31:0] alu,
                       input logic [31:0] rd2, input logic tk, input logic [31:0] tg, input bit chkr);
      exp_t e;
      if (mode == LOAD) begin
         cur.alu = alu; cur.rd2 = rd2; cur.pc4 = i_id_pc_plus_4; cur.dest = i_id_reg_dest;
         cur.reg_wr = i_id_reg_wr; cur.mem_wr = i_id_mem_wr; cur.mem_rd = i_id_mem_rd;
         cur.mem_to_reg = i_id_mem_to_reg; cur.rw_sel = i_id_rw_sel;
      end else if (mode == BUBBLE) begin
         cur.alu = '0; cur.rd2 = '0; cur.pc4 = '0; cur.dest = '0; cur.reg_wr = 0;
         cur.mem_wr = 0; cur.mem_rd = 0; cur.mem_to_reg = 0; cur.rw_sel = '0;
      end
      e = cur;
      e.name = nm; e.taken = tk; e.target = tg; e.chk_regs = chkr;
      sb_q.push_back(e);
      @(negedge i_clk);
   endtask

   // Monitor: one expectation per clock, sampled just after the rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge i_clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.name, "/taken"}, 32'(o_branch_taken), 32'(e.taken));
            chk({e.name, "/target"}, o_branch_target, e.target);
            if (e.chk_regs) begin
               chk({e.name, "/alu"}, o_ex_alu_result, e.alu);
               chk({e.name, "/pc4"}, o_ex_pc_plus_4, e.pc4);
               chk({e.name, "/rd2"}, o_ex_reg_read_data2, e.rd2);
               chk({e.name, "/dest"}, 32'(o_ex_reg_dest), 32'(e.dest));
               chk({e.name, "/ctrl"},
                   32'({o_ex_reg_wr, o_ex_mem_wr, o_ex_mem_rd, o_ex_mem_to_reg, o_ex_rw_sel}),
                   32'({e.reg_wr, e.mem_wr, e.mem_rd, e.mem_to_reg, e.rw_sel}));
            end
         end
      end
   end

   initial begin
      int waited;
      i_rst = 1'b1;
      clear_in();
      @(negedge i_clk);
      chk("rst/alu", o_ex_alu_result, 32'h0);
      chk("rst/pc4", o_ex_pc_plus_4, 32'h4);
      chk("rst/ctrl", 32'({o_ex_reg_wr, o_ex_mem_wr, o_ex_mem_rd, o_ex_mem_to_reg}), 32'h0);
      chk("rst/taken", 32'(o_branch_taken), 32'h0);
      cur = '{name: "", taken: 0, target: '0, chk_regs: 0, alu: '0, pc4: 32'h4, rd2: '0,
              dest: '0, reg_wr: 0, mem_wr: 0, mem_rd: 0, mem_to_reg: 0, rw_sel: '0};
      i_rst = 1'b0;

      // R-type ADD / SUB
      clear_in(); i_id_pc = 32'h10; i_id_pc_plus_4 = 32'h14; i_id_rs1_addr = 1; i_id_rs2_addr = 2;
      i_id_rs1_data = 5; i_id_rs2_data = 7; i_id_reg_dest = 3; i_id_alu_op = 2'b10; i_id_reg_wr = 1;
      step("add", LOAD, 32'd12, 32'd7, 0, 32'h10, 1);
      clear_in(); i_id_pc = 32'h14; i_id_pc_plus_4 = 32'h18; i_id_rs1_addr = 1; i_id_rs2_addr = 2;
      i_id_rs1_data = 3; i_id_rs2_data = 5; i_id_funct7 = 7'h20; i_id_reg_dest = 4;
      i_id_alu_op = 2'b10; i_id_reg_wr = 1;
      step("sub", LOAD, 32'hFFFF_FFFE, 32'd5, 0, 32'h14, 1);

      // SRAI and ADDI whose immediate has bit 10 set (must not subtract)
      clear_in(); i_id_pc = 32'h18; i_id_pc_plus_4 = 32'h1C; i_id_rs1_addr = 1;
      i_id_rs1_data = 32'h8000_0000; i_id_imm = 32'h404; i_id_funct3 = 3'b101; i_id_funct7 = 7'h20;
      i_id_alu_op = 2'b11; i_id_alu_src = 1; i_id_reg_dest = 5; i_id_reg_wr = 1;
      step("srai", LOAD, 32'hF800_0000, 32'h0, 0, 32'h41C, 1);
      clear_in(); i_id_pc = 32'h1C; i_id_pc_plus_4 = 32'h20; i_id_rs1_addr = 1; i_id_rs1_data = 10;
      i_id_imm = 32'h403; i_id_funct7 = 7'h20; i_id_alu_op = 2'b11; i_id_alu_src = 1;
      i_id_reg_dest = 6; i_id_reg_wr = 1;
      step("addi_f7", LOAD, 32'h40D, 32'h0, 0, 32'h41F, 1);

      // Forwarding priority and x0 exclusion
      clear_in(); i_id_pc = 32'h20; i_id_pc_plus_4 = 32'h24; i_id_rs1_addr = 1; i_id_rs1_data = 7;
      i_id_imm = 1; i_id_alu_op = 2'b11; i_id_alu_src = 1; i_id_reg_dest = 7; i_id_reg_wr = 1;
      i_ma_reg_wr = 1; i_ma_reg_dest = 1; i_ma_result = 100;
      i_wb_reg_wr = 1; i_wb_reg_dest = 1; i_wb_data = 50;
      step("fwd_ma", LOAD, 32'd101, 32'h0, 0, 32'h21, 1);
      i_ma_reg_wr = 0;
      step("fwd_wb", LOAD, 32'd51, 32'h0, 0, 32'h21, 1);
      i_ma_reg_wr = 1; i_ma_reg_dest = 0; i_wb_reg_dest = 0; i_id_rs1_addr = 0; i_id_rs1_data = 9;
      step("fwd_x0", LOAD, 32'd10, 32'h0, 0, 32'h21, 1);

      // Store with MA-forwarded store data, then flush+stall (flush wins)
      clear_in(); i_id_pc = 32'h30; i_id_pc_plus_4 = 32'h34; i_id_rs1_addr = 2; i_id_rs1_data = 32'h18;
      i_id_imm = 8; i_id_rs2_addr = 5; i_id_rs2_data = 32'h99; i_id_funct3 = 3'b010;
      i_id_alu_src = 1; i_id_mem_wr = 1; i_ma_reg_wr = 1; i_ma_reg_dest = 5; i_ma_result = 32'h41;
      step("sw", LOAD, 32'h20, 32'h41, 0, 32'h38, 1);
      clear_in(); i_id_pc = 32'h10; i_id_pc_plus_4 = 32'h14; i_id_rs1_data = 5; i_id_rs2_data = 7;
      i_id_reg_dest = 3; i_id_alu_op = 2'b10; i_id_reg_wr = 1; i_id_jal = 1;
      i_flush = 1; i_stall = 1;
      step("flush", BUBBLE, 32'h0, 32'h0, 0, 32'h10, 1);

      // Conditional branches
      clear_in(); i_id_pc = 32'h40; i_id_pc_plus_4 = 32'h44; i_id_imm = 32'h10; i_id_rs1_addr = 1;
      i_id_rs2_addr = 2; i_id_rs1_data = 32'hFFFF_FFFF; i_id_rs2_data = 1; i_id_alu_op = 2'b01;
      i_id_branch = 1;
      i_id_funct3 = 3'b100; step("blt", LOAD, 32'h0, 32'h1, 1, 32'h50, 0);
      i_id_funct3 = 3'b110; step("bltu", LOAD, 32'h0, 32'h1, 0, 32'h50, 0);
      i_id_funct3 = 3'b101; step("bge", LOAD, 32'h0, 32'h1, 0, 32'h50, 0);
      i_id_funct3 = 3'b111; step("bgeu", LOAD, 32'h0, 32'h1, 1, 32'h50, 0);
      i_id_rs1_data = 3; i_id_rs2_data = 4; i_ma_reg_wr = 1; i_ma_reg_dest = 2; i_ma_result = 3;
      i_id_funct3 = 3'b000; step("beq_fwd", LOAD, 32'h0, 32'h3, 1, 32'h50, 0);
      i_id_funct3 = 3'b001; step("bne_fwd", LOAD, 32'h0, 32'h3, 0, 32'h50, 0);

      // JALR, then JALR under stall, JAL with clock enable low, JAL
      clear_in(); i_id_pc = 32'h80; i_id_pc_plus_4 = 32'h84; i_id_rs1_addr = 1; i_id_rs1_data = 32'h103;
      i_id_imm = 4; i_id_alu_src = 1; i_id_jalr = 1; i_id_reg_wr = 1; i_id_reg_dest = 1;
      i_id_rw_sel = 2'b10;
      step("jalr", LOAD, 32'h107, 32'h0, 1, 32'h106, 1);
      i_stall = 1;
      step("jalr_stall", HOLD, 32'h0, 32'h0, 0, 32'h106, 1);
      clear_in(); i_id_pc = 32'h100; i_id_pc_plus_4 = 32'h104; i_id_imm = 32'hFFFF_FFF8;
      i_id_alu_src = 1; i_id_jal = 1; i_id_reg_wr = 1; i_id_reg_dest = 9; i_id_rw_sel = 2'b10;
      i_clk_en = 0;
      step("jal_noen", HOLD, 32'h0, 32'h0, 0, 32'hF8, 1);
      i_clk_en = 1;
      step("jal", LOAD, 32'hFFFF_FFF8, 32'h0, 1, 32'hF8, 1);

      // LUI and AUIPC
      clear_in(); i_id_pc = 32'h200; i_id_pc_plus_4 = 32'h204; i_id_rs1_addr = 3; i_id_rs1_data = 32'h55;
      i_id_imm = 32'h1234_5000; i_id_alu_src = 1; i_id_lui = 1; i_id_reg_wr = 1; i_id_reg_dest = 8;
      step("lui", LOAD, 32'h1234_5000, 32'h0, 0, 32'h1234_5200, 1);
      i_id_lui = 0; i_id_auipc = 1; i_id_imm = 32'h1000;
      step("auipc", LOAD, 32'h1200, 32'h0, 0, 32'h1200, 1);

      // Remaining R-type functions
      clear_in(); i_id_pc = 32'h300; i_id_pc_plus_4 = 32'h304; i_id_rs1_addr = 1; i_id_rs2_addr = 2;
      i_id_alu_op = 2'b10; i_id_reg_wr = 1; i_id_reg_dest = 10;
      i_id_rs1_data = 32'hFFFF_FFFF; i_id_rs2_data = 1;
      i_id_funct3 = 3'b010; step("slt", LOAD, 32'h1, 32'h1, 0, 32'h300, 1);
      i_id_funct3 = 3'b011; step("sltu", LOAD, 32'h0, 32'h1, 0, 32'h300, 1);
      i_id_rs1_data = 3; i_id_rs2_data = 32'h21;
      i_id_funct3 = 3'b001; step("sll", LOAD, 32'h6, 32'h21, 0, 32'h300, 1);
      i_id_rs1_data = 32'hF0F0; i_id_rs2_data = 32'h0FF0;
      i_id_funct3 = 3'b100; step("xor", LOAD, 32'hFF00, 32'h0FF0, 0, 32'h300, 1);
      i_id_funct3 = 3'b111; step("and", LOAD, 32'h00F0, 32'h0FF0, 0, 32'h300, 1);
      i_id_rs1_data = 32'h8000_0000; i_id_rs2_data = 4;
      i_id_funct3 = 3'b101; step("srl", LOAD, 32'h0800_0000, 32'h4, 0, 32'h300, 1);

      // Load word: address plus load control bits
      clear_in(); i_id_pc = 32'h400; i_id_pc_plus_4 = 32'h404; i_id_rs1_addr = 1; i_id_rs1_data = 32'h100;
      i_id_imm = 4; i_id_alu_src = 1; i_id_funct3 = 3'b010; i_id_mem_rd = 1; i_id_mem_to_reg = 1;
      i_id_reg_wr = 1; i_id_reg_dest = 11; i_id_rw_sel = 2'b01;
      step("lw", LOAD, 32'h104, 32'h0, 0, 32'h404, 1);

      // Drain scoreboard with a bounded wait
      waited = 0;
      while (sb_q.size() > 0 && waited < 10) begin
         @(negedge i_clk);
         waited++;
      end
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end

      // Asynchronous reset between clock edges
      @(posedge i_clk);
      #3;
      i_rst = 1'b1;
      #1;
      chk("arst/alu", o_ex_alu_result, 32'h0);
      chk("arst/pc4", o_ex_pc_plus_4, 32'h4);
      chk("arst/dest", 32'(o_ex_reg_dest), 32'h0);
      chk("arst/ctrl", 32'({o_ex_reg_wr, o_ex_mem_wr, o_ex_mem_rd, o_ex_mem_to_reg, o_ex_rw_sel}), 32'h0);
      chk("arst/f3", 32'(o_ex_funct3), 32'h0);
      @(negedge i_clk);
      i_rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
